// File: rtl/pac_man_pkg.sv
// Shared types for the Pac-Man move-commit stage: tile encoding, block index, commit FSM states.
// Also holds the maze geometry defaults and a saturating score adder.
package pac_man_pkg;

    localparam int DEF_GRID_W     = 32;
    localparam int DEF_NUM_BLOCKS = 960;
    localparam int BLOCK_W        = 10;

    typedef logic [BLOCK_W-1:0] block_t;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        WALL   = 2'd1,
        PELLET = 2'd2,
        POWER  = 2'd3
    } tile_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_WAIT   = 3'd2,
        ST_READ   = 3'd3,
        ST_CHECK  = 3'd4,
        ST_COMMIT = 3'd5
    } commit_state_t;

    // The 17th bit of the sum is the overflow flag; clamp instead of wrapping.
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/move_tick_gen.sv
// Free-running move-rate counter: pulses tick on the last count of every MOVE_PERIOD cycles.
// Latency: tick is a decode of the counter register; no backpressure, runs regardless of enable.
// Backpressure: none.
module move_tick_gen #(
    parameter int MOVE_PERIOD = 8
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_o
);

    localparam int CW = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(MOVE_PERIOD - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/pac_man_move_commit.sv
// Commits Pac-Man moves: requests a candidate, checks it against the maze tile RAM, eats pellets.
// Latency: done -> curr_block update in 3 cycles; start pulses at most once per MOVE_PERIOD.
// Backpressure: done is only accepted in WAIT; anything outside WAIT is dropped, never queued.
module pac_man_move_commit
    import pac_man_pkg::*;
#(
    parameter int NUM_BLOCKS  = DEF_NUM_BLOCKS,
    parameter int START_BLOCK = 495,
    parameter int MOVE_PERIOD = 8,
    parameter int PELLET_PTS  = 10,
    parameter int POWER_PTS   = 50
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic        start,
    input  logic        done,
    input  logic [9:0]  next_block,
    output logic [9:0]  tile_addr,
    input  logic [1:0]  tile_rdata,
    output logic        tile_we,
    output logic [1:0]  tile_wdata,
    output logic [9:0]  curr_block,
    output logic        moved,
    output logic        pellet_eaten,
    output logic        power_eaten,
    output logic [15:0] score
);

    localparam block_t      MAX_BLOCK = block_t'(NUM_BLOCKS - 1);
    localparam block_t      START_B   = block_t'(START_BLOCK);
    localparam logic [15:0] PELLET_V  = 16'(PELLET_PTS);
    localparam logic [15:0] POWER_V   = 16'(POWER_PTS);

    commit_state_t state_q, state_d;
    block_t        cand_q, cand_d;
    block_t        curr_q, curr_d;
    logic [15:0]   score_q, score_d;
    logic          moved_q, moved_d;
    logic          pellet_q, pellet_d;
    logic          power_q, power_d;
    logic          tick;
    logic          legal;
    logic          edible;

    move_tick_gen #(
        .MOVE_PERIOD(MOVE_PERIOD)
    ) u_tick (
        .clk   (clk),
        .rst_n (reset),
        .tick_o(tick)
    );

    // tile_rdata is valid in CHECK because the address was registered at the WAIT latch.
    assign legal  = (cand_q <= MAX_BLOCK) && (cand_q != curr_q) && (tile_rdata != WALL);
    assign edible = (tile_rdata == PELLET) || (tile_rdata == POWER);

    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        curr_d   = curr_q;
        score_d  = score_q;
        moved_d  = 1'b0;
        pellet_d = 1'b0;
        power_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tick && enable) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (done) begin
                    cand_d  = next_block;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (legal) begin
                    curr_d  = cand_q;
                    moved_d = 1'b1;
                    if (edible) begin
                        pellet_d = 1'b1;
                        power_d  = (tile_rdata == POWER);
                        score_d  = sat_add16(score_q, (tile_rdata == POWER) ? POWER_V : PELLET_V);
                    end
                    state_d = ST_COMMIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cand_q   <= '0;
            curr_q   <= START_B;
            score_q  <= '0;
            moved_q  <= 1'b0;
            pellet_q <= 1'b0;
            power_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cand_q   <= cand_d;
            curr_q   <= curr_d;
            score_q  <= score_d;
            moved_q  <= moved_d;
            pellet_q <= pellet_d;
            power_q  <= power_d;
        end
    end

    assign start        = (state_q == ST_REQ);
    assign tile_addr    = cand_q;
    assign tile_we      = pellet_q;
    assign tile_wdata   = EMPTY;
    assign curr_block   = curr_q;
    assign moved        = moved_q;
    assign pellet_eaten = pellet_q;
    assign power_eaten  = power_q;
    assign score        = score_q;

endmodule
